// File: rtl/filter_frame_ctrl.sv
// Frame controller for a 3x3 window filter datapath.
// Walks one IMG_W x IMG_H frame of pixel/gauss pairs into the datapath.
// Tags the pixels whose window is fully inside the frame and tracks them through
// the datapath latency. Presents only interior results, marking the last one.
module filter_frame_ctrl #(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned DP_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_image,
    input  logic [9:0] in_gauss,
    output logic       dp_clken,
    output logic       dp_aclr,
    output logic [9:0] dp_image,
    output logic [9:0] dp_gauss,
    input  logic [9:0] dp_result,
    output logic       out_valid,
    output logic [9:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);
    localparam int unsigned NOUT = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DP_LAT-1:0] tag_q, tag_d;
    logic [31:0]       out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [9:0]        out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic accept;
    logic at_last_col;
    logic at_last_row;
    logic win_tag;
    logic tag_out;

    assign in_ready    = (state_q == StRun);
    assign accept      = in_valid & in_ready;
    assign dp_clken    = accept;
    assign dp_aclr     = (state_q == StClear);
    assign dp_image    = in_image;
    assign dp_gauss    = in_gauss;
    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StDone);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

    assign at_last_col = (col_q == CW'(IMG_W - 1));
    assign at_last_row = (row_q == RW'(IMG_H - 1));
    // Only pixels with two full rows and columns behind them complete a 3x3 window.
    assign win_tag     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign tag_out     = tag_q[DP_LAT-1];

    // State register and all controller state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            tag_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tag_q       <= tag_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic and pixel position counters.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                col_d   = '0;
                row_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                if (accept) begin
                    if (at_last_col) begin
                        col_d = '0;
                        if (at_last_row) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDrain: begin
                // The final pixel is always interior, so its output closes the frame.
                if ((tag_q == '0) && out_valid_q && out_last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Tag pipeline mirrors datapath latency; results are captured when a tag reaches the end.
    always_comb begin
        tag_d[0] = win_tag;
        for (int unsigned i = 1; i < DP_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        out_valid_d = tag_out;
        out_data_d  = tag_out ? dp_result : out_data_q;
        out_last_d  = tag_out && (out_cnt_q == 32'(NOUT - 1));
        out_cnt_d   = out_cnt_q;
        if (state_q == StClear) begin
            out_cnt_d = '0;
        end else if (tag_out) begin
            out_cnt_d = out_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Scoreboard bench for filter_frame_ctrl: the driver pushes expected outputs
// derived from frame geometry, and a monitor pops them on every out_valid.
module tb_filter_frame_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned LAT  = 2;
    localparam int          NPIX = W * H;
    localparam int          NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_image = '0;
    logic [9:0] in_gauss = '0;
    logic [9:0] dp_result = '0;
    logic       in_ready, dp_clken, dp_aclr, out_valid, out_last, busy, frame_done;
    logic [9:0] dp_image, dp_gauss, out_data;

    typedef struct {
        int         cyc;
        logic [9:0] data;
        bit         last;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         cmode = 1'b0;
    logic [9:0] hold_data = '0;
    int         outs_seen = 0;
    int         done_seen = 0;
    int         frames_done = 0;
    int         fr_k = 0;
    int         t_last = 0;

    filter_frame_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .DP_LAT(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_image  (in_image),
        .in_gauss  (in_gauss),
        .dp_clken  (dp_clken),
        .dp_aclr   (dp_aclr),
        .dp_image  (dp_image),
        .dp_gauss  (dp_gauss),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: result seen during cycle c is a known function of c.
    function automatic logic [9:0] res_at(input int c);
        if (cmode) return 10'h155;
        return 10'((c * 397 + 123) ^ (c >> 2));
    endfunction

    always @(posedge clk) begin
        #1;
        dp_result = res_at(cyc);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every presented output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                outs_seen++;
                chk("out_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("out_last", int'(out_last), int'(e.last));
                    hold_data = e.data;
                end
            end else begin
                chk("out_hold", int'(out_data), int'(hold_data));
            end
            if (frame_done) done_seen++;
        end
    end

    task automatic step_inputs(input bit v, input bit st);
        @(posedge clk);
        #1;
        in_valid = v;
        start    = st;
        in_image = 10'($urandom);
        in_gauss = 10'($urandom);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input bit v);
        step_inputs(v, 1'b0);
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_clken", int'(dp_clken), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic start_frame();
        step_inputs(1'($urandom), 1'b1);
        chk("start_ready", int'(in_ready), 0);
        chk("start_clken", int'(dp_clken), 0);
        chk("start_busy", int'(busy), 0);
        step_inputs(1'($urandom), 1'b0);
        chk("clear_aclr", int'(dp_aclr), 1);
        chk("clear_ready", int'(in_ready), 0);
        chk("clear_clken", int'(dp_clken), 0);
        chk("clear_busy", int'(busy), 1);
        fr_k      = 0;
        outs_seen = 0;
    endtask

    // One RUN cycle; the model derives position and window tag from the acceptance count.
    task automatic feed(input bit v, input bit st);
        int   r, c;
        exp_t e;
        step_inputs(v, st);
        chk("run_ready", int'(in_ready), 1);
        chk("run_clken", int'(dp_clken), int'(v));
        chk("run_aclr", int'(dp_aclr), 0);
        chk("pass_image", int'(dp_image), int'(in_image));
        chk("pass_gauss", int'(dp_gauss), int'(in_gauss));
        if (v) begin
            r = fr_k / W;
            c = fr_k % W;
            if (r >= 2 && c >= 2) begin
                e.cyc  = cyc + LAT + 1;
                e.data = res_at(cyc + LAT);
                e.last = (fr_k == NPIX - 1);
                sb.push_back(e);
            end
            if (fr_k == NPIX - 1) t_last = cyc;
            fr_k++;
        end
    endtask

    // mode 0: back-to-back, 1: alternating, 2: random gaps.
    task automatic feed_frame(input int mode, input bit start_mid);
        bit v;
        bit alt = 1'b1;
        bit pulsed = 1'b0;
        bit st;
        while (fr_k < NPIX) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = alt;
            else v = ($urandom_range(0, 2) != 0);
            alt = ~alt;
            st  = start_mid && !pulsed && fr_k == 5;
            if (st) pulsed = 1'b1;
            feed(v, st);
        end
    endtask

    task automatic finish_frame();
        int n = 0;
        do begin
            step_inputs(1'($urandom), 1'($urandom));
            chk("drain_ready", int'(in_ready), 0);
            chk("drain_clken", int'(dp_clken), 0);
            chk("drain_busy", int'(busy), 1);
            n++;
        end while (!frame_done && n < 40);
        chk("done_seen", int'(frame_done), 1);
        chk("done_cycle", cyc, t_last + LAT + 2);
        step_inputs(1'b0, 1'b0);
        chk("after_done_busy", int'(busy), 0);
        chk("after_done_pulse", int'(frame_done), 0);
        chk("frame_outputs", outs_seen, NOUT);
        chk("sb_empty", sb.size(), 0);
        frames_done++;
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_dp_clken", int'(dp_clken), 0);
        chk("rst_dp_aclr", int'(dp_aclr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values();

        // in_valid without start must be ignored.
        repeat (5) idle_cycle(1'b1);

        // Constant result, back-to-back then alternating.
        cmode = 1'b1;
        start_frame();
        feed_frame(0, 1'b0);
        finish_frame();
        idle_cycle(1'b0);
        start_frame();
        feed_frame(1, 1'b0);
        finish_frame();

        // Varying result, start pulsed mid-frame.
        cmode = 1'b0;
        idle_cycle(1'b0);
        start_frame();
        feed_frame(2, 1'b1);
        finish_frame();

        // Reset after 7 accepted pixels, then a fresh frame.
        idle_cycle(1'b0);
        start_frame();
        repeat (7) feed(1'b1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        @(negedge clk);
        sb.delete();
        hold_data = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values();
        repeat (5) idle_cycle(1'b1);
        start_frame();
        feed_frame(0, 1'b0);
        finish_frame();

        // Randomised frames with random idle gaps between them.
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) idle_cycle(1'($urandom));
            start_frame();
            feed_frame(2, 1'($urandom));
            finish_frame();
        end

        repeat (4) idle_cycle(1'b0);
        chk("frame_done_total", done_seen, frames_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/filter_frame_ctrl.md
FILTER_FRAME_CTRL -- requirements
Module: filter_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (minimum 3).
REQ-002 Parameter IMG_H, default 480, lines per frame (minimum 3).
REQ-003 Parameter DP_LAT, default 2, clocks from a datapath clock-enable to a valid result on dp_result.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-007 in_valid  in  1  upstream pixel/gauss pair valid.
REQ-008 in_ready  out  1  controller accepts the pair this cycle.
REQ-009 in_image  in  10  image pixel.
REQ-010 in_gauss  in  10  gauss-exponent sample.
REQ-011 dp_clken  out  1  datapath window-shift enable (per_clken).
REQ-012 dp_aclr  out  1  datapath line-buffer clear.
REQ-013 dp_image, dp_gauss  out  10 each  datapath inputs.
REQ-014 dp_result  in  10  saturated weighted sum from the datapath.
REQ-015 out_valid  out  1  out_data valid.
REQ-016 out_data  out  10  filtered interior pixel.
REQ-017 out_last  out  1  marks the final interior pixel of the frame.
REQ-018 busy  out  1  high outside IDLE.
REQ-019 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-021 IDLE: start=1 -> CLEAR; start ignored in every other state.
REQ-022 CLEAR lasts exactly 1 cycle with dp_aclr=1; col/row/output counters zeroed; then RUN.
REQ-023 RUN: in_ready=1; a pair is accepted when in_valid&in_ready.
REQ-024 in_ready SHALL be 0 in IDLE, CLEAR, DRAIN and DONE; in_valid there is ignored.
REQ-025 dp_clken = in_valid & in_ready (combinational); dp_image/dp_gauss = in_image/in_gauss passthrough.
REQ-026 col counts 0..IMG_W-1 per acceptance, wraps to 0 and increments row; row counts 0..IMG_H-1.
REQ-027 An accepted pixel at (row,col) with row>=2 and col>=2 SHALL be tagged window-valid; all other pixels are untagged (no border output).
REQ-028 The tag enters a DP_LAT-stage shift register advancing every cycle; at stage DP_LAT the controller registers dp_result into out_data and asserts out_valid in the following cycle (acceptance at t -> out_valid at t+DP_LAT+1).
REQ-029 Output count per frame SHALL be exactly (IMG_W-2)*(IMG_H-2); out_last coincides with the final out_valid.
REQ-030 Acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
REQ-031 DRAIN holds until the tag pipeline is empty and the last output has been presented, then DONE.
REQ-032 DONE lasts 1 cycle with frame_done=1, then IDLE.
REQ-033 in_valid gaps in RUN stall counters and tags only; pipeline stages already in flight continue to drain.
REQ-034 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-035 rst_n=0 at a clock edge, in any state including mid-frame, SHALL return to IDLE and clear counters, tag pipeline, and pending output.
REQ-036 Reset values: in_ready=0, dp_clken=0, dp_aclr=0, out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0.
REQ-037 A frame interrupted by reset produces no further out_valid; the next start begins a fresh frame with dp_aclr.

Verification
REQ-038 IMG_W=4, IMG_H=3, DP_LAT=2, 12 back-to-back pixels, constant dp_result=0x155 -> exactly 2 out_valid at acceptance(2,2)+3 and acceptance(2,3)+3, data 0x155, out_last on the second; frame_done 1 cycle after DRAIN exits.
REQ-039 Same frame with in_valid toggling every other cycle -> identical output count/data, each out_valid exactly DP_LAT+1 cycles after its acceptance.
REQ-040 start pulsed during RUN -> ignored; col/row unaffected; single frame_done.
REQ-041 rst_n low for 1 cycle after 7 accepted pixels -> all outputs at reset values next cycle; no out_valid afterwards; new start -> dp_aclr pulse, full 2-output frame.
REQ-042 in_valid high in IDLE without start -> in_ready=0, dp_clken=0, no outputs.
REQ-043 Default parameters, full 640x480 frame -> 638*478=304964 outputs, one out_last, one frame_done.
